// File: rtl/dense_argmax_head_if.sv
// dense_argmax_head_if: the pooled-feature stream, the weight/bias load port and the result signals.
interface dense_argmax_head_if #(
  parameter int H = 32,
  parameter int K = 4,
  parameter int DW = 16
);
  logic feat_valid, feat_ready, w_we, b_we, out_valid, overrun;
  logic signed [DW-1:0] feat_data, w_data, b_data, max_score;
  logic [$clog2(H*K)-1:0] w_addr;
  logic [$clog2(K)-1:0] b_addr, class_idx;
  modport master (
    output feat_valid, feat_data, w_we, w_addr, w_data, b_we, b_addr, b_data,
    input feat_ready, out_valid, class_idx, max_score, overrun
  );
  modport slave (
    input feat_valid, feat_data, w_we, w_addr, w_data, b_we, b_addr, b_data,
    output feat_ready, out_valid, class_idx, max_score, overrun
  );
endinterface

// File: rtl/dense_argmax_head.sv
// dense_argmax_head: K-class dense layer over a streamed pooled vector with one shared multiplier, then argmax.
// Define DENSE_ROUND_EN to round scores half up instead of truncating toward -inf.
module dense_argmax_head #(
  parameter int H = 32,
  parameter int K = 4,
  parameter int DW = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 40
) (
  input logic clk,
  input logic rst,
  dense_argmax_head_if.slave bus
);
  localparam int AW = $clog2(H * K);
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(H + 1);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;
`ifdef DENSE_ROUND_EN
  localparam logic signed [ACCW-1:0] RND = ACCW'(1) <<< (FRAC - 1);
`else
  localparam logic signed [ACCW-1:0] RND = '0;
`endif
  typedef enum logic [2:0] {IDLE, MAC, BIAS, ARGMAX, DONE} state_e;
  state_e state_q, state_d;
  logic [KW-1:0] cls_q, cls_d, best_idx_q, best_idx_d, idx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [DW-1:0] w_mem [H*K];
  logic signed [DW-1:0] b_mem [K];
  logic signed [ACCW-1:0] acc_q [K];
  logic signed [DW-1:0] score_q [K];
  logic signed [DW-1:0] feat_q, best_q, best_d, max_q, sat, cand;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext, bias_ext, sum, shifted;
  logic [AW-1:0] w_idx;
  logic cls_last, cnt_last, wr_ok, better, overrun_q;
  assign cls_last = cls_q == KW'(K - 1);
  assign cnt_last = cnt_q == CW'(H - 1);
  assign wr_ok = state_q == IDLE && cnt_q == '0;
  assign w_idx = AW'(cnt_q * K + cls_q);
  assign prod = (2*DW)'(feat_q) * (2*DW)'(w_mem[w_idx]);
  assign prod_ext = ACCW'(prod);
  // bias is aligned to the product's 2*FRAC binary point before the rescale
  assign bias_ext = ACCW'(b_mem[cls_q]) <<< FRAC;
  assign sum = acc_q[cls_q] + bias_ext + RND;
  assign shifted = sum >>> FRAC;
  assign sat = shifted > SMAX ? DW'(SMAX) : shifted < SMIN ? DW'(SMIN) : DW'(shifted);
  assign cand = score_q[cls_q];
  assign better = cls_q == '0 || cand > best_q;
  assign best_d = better ? cand : best_q;
  assign best_idx_d = better ? cls_q : best_idx_q;
  assign bus.feat_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.class_idx = idx_q;
  assign bus.max_score = max_q;
  assign bus.overrun = overrun_q;
  always_comb begin
    state_d = state_q;
    cls_d = (state_q == IDLE || cls_last) ? '0 : cls_q + KW'(1);
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = bus.feat_valid ? MAC : IDLE;
      MAC: begin
        cnt_d = !cls_last ? cnt_q : cnt_last ? '0 : cnt_q + CW'(1);
        state_d = !cls_last ? MAC : cnt_last ? BIAS : IDLE;
      end
      BIAS: state_d = cls_last ? ARGMAX : BIAS;
      ARGMAX: state_d = cls_last ? DONE : ARGMAX;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < K; i++) acc_q[i] <= '0;
      idx_q <= '0;
      max_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      cnt_q <= cnt_d;
      if (bus.feat_valid && state_q != IDLE) overrun_q <= 1'b1;
      if (state_q == MAC) acc_q[cls_q] <= acc_q[cls_q] + prod_ext;
      if (state_q == BIAS) acc_q[cls_q] <= '0;
      if (state_q == ARGMAX && cls_last) begin
        idx_q <= best_idx_d;
        max_q <= best_d;
      end
    end
  end
  // coefficients survive reset; loads are only accepted between samples
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.feat_valid) feat_q <= bus.feat_data;
    if (state_q == BIAS) score_q[cls_q] <= sat;
    if (state_q == ARGMAX) begin
      best_q <= best_d;
      best_idx_q <= best_idx_d;
    end
    if (!rst && wr_ok && bus.w_we) w_mem[bus.w_addr] <= bus.w_data;
    if (!rst && wr_ok && bus.b_we) b_mem[bus.b_addr] <= bus.b_data;
  end
endmodule

// File: tb/tb_dense_argmax_head.sv
// tb_dense_argmax_head: scoreboard bench for dense_argmax_head against a behavioural integer model.
module tb_dense_argmax_head;
  localparam int H = 32, K = 4, DW = 16, FRAC = 8;
  localparam int AW = $clog2(H * K), KW = $clog2(K);
`ifdef DENSE_ROUND_EN
  localparam longint RND = 64'sd1 <<< (FRAC - 1);
`else
  localparam longint RND = 0;
`endif
  typedef struct { int idx; int score; int cyc; } exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, acc_cyc = 0, n_checks = 0, n_fail = 0;
  int wm [H*K];
  int bm [K];
  int fv [H];
  exp_t sb [$];
  exp_t got_e;
  dense_argmax_head_if #(.H(H), .K(K), .DW(DW)) bus ();
  dense_argmax_head #(.H(H), .K(K), .DW(DW), .FRAC(FRAC), .ACCW(40)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model();
    exp_t e;
    longint a;
    e.idx = 0;
    e.score = 0;
    e.cyc = 0;
    for (int c = 0; c < K; c++) begin
      a = 0;
      for (int f = 0; f < H; f++) a += longint'(fv[f]) * longint'(wm[f*K+c]);
      a = (a + (longint'(bm[c]) <<< FRAC) + RND) >>> FRAC;
      a = a > 32767 ? 32767 : a < -32768 ? -32768 : a;
      if (c == 0 || a > e.score) begin
        e.idx = c;
        e.score = int'(a);
      end
    end
    return e;
  endfunction
  task automatic load();
    for (int i = 0; i < H*K; i++) begin
      bus.w_we = 1;
      bus.w_addr = AW'(i);
      bus.w_data = 16'(wm[i]);
      bus.b_we = i < K;
      bus.b_addr = KW'(i);
      bus.b_data = 16'(bm[i % K]);
      @(posedge clk); #1;
    end
    bus.w_we = 0;
    bus.b_we = 0;
  endtask
  task automatic send(input int d, input bit wr, input int wa, input int wd);
    int n = 0;
    while (!bus.feat_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("feat_ready_wait", bus.feat_ready, 1);
    bus.feat_valid = 1;
    bus.feat_data = 16'(d);
    bus.w_we = wr;
    bus.w_addr = AW'(wa);
    bus.w_data = 16'(wd);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.feat_valid = 0;
    bus.w_we = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask
  // ovr_at: inject a dropped feature right after feature ovr_at; wr_at: weight write alongside feature wr_at
  task automatic run_sample(input int ovr_at, input int wr_at, input int wa, input int wd);
    exp_t e;
    for (int f = 0; f < H; f++) begin
      send(fv[f], f == wr_at, wa, wd);
      if (f == wr_at && f == 0) wm[wa] = wd;
      if (f == ovr_at) begin
        bus.feat_valid = 1;
        bus.feat_data = 16'h7FFF;
        @(posedge clk); #1;
        bus.feat_valid = 0;
      end
    end
    e = model();
    e.cyc = acc_cyc + 3 * K;
    sb.push_back(e);
    drain();
  endtask
  always @(negedge clk) begin
    if (bus.out_valid) begin
      check("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        check("class_idx", bus.class_idx, got_e.idx);
        check("max_score", bus.max_score, got_e.score);
        check("latency", cyc - got_e.cyc, 0);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.feat_valid = 0; bus.feat_data = 0; bus.w_we = 0; bus.w_addr = 0; bus.w_data = 0;
    bus.b_we = 0; bus.b_addr = 0; bus.b_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.feat_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_idx", bus.class_idx, 0);
    check("rst_score", bus.max_score, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 0;
    for (int i = 0; i < H*K; i++) wm[i] = (i % K == 2) ? 'h200 : 'h100;
    for (int c = 0; c < K; c++) bm[c] = 0;
    for (int f = 0; f < H; f++) fv[f] = 'h80;
    load();
    run_sample(-1, -1, 0, 0);
    check("basic_idx", bus.class_idx, 2);
    check("basic_score", bus.max_score, 'h2000);
    for (int i = 0; i < H*K; i++) wm[i] = 0;
    bm = '{256, 768, 768, -256};
    load();
    run_sample(-1, -1, 0, 0);
    check("tie_idx", bus.class_idx, 1);
    check("tie_score", bus.max_score, 'h300);
    for (int i = 0; i < H*K; i++) wm[i] = 32767;
    for (int c = 0; c < K; c++) bm[c] = 0;
    for (int f = 0; f < H; f++) fv[f] = 32767;
    load();
    run_sample(-1, -1, 0, 0);
    check("satp_idx", bus.class_idx, 0);
    check("satp_score", bus.max_score, 32767);
    for (int f = 0; f < H; f++) fv[f] = -32768;
    run_sample(-1, -1, 0, 0);
    check("satn_idx", bus.class_idx, 0);
    check("satn_score", bus.max_score, -32768);
    for (int i = 0; i < H*K; i++) wm[i] = (i % K == 2) ? 'h200 : 'h100;
    load();
    for (int f = 0; f < H; f++) fv[f] = 'h80;
    run_sample(0, 5, 5 * K + 1, 'h7FFF);
    check("ovr_set", bus.overrun, 1);
    check("ovr_idx", bus.class_idx, 2);
    check("ovr_score", bus.max_score, 'h2000);
    for (int f = 0; f < H; f++) fv[f] = 'h100;
    run_sample(-1, -1, 0, 0);
    check("lock_idx", bus.class_idx, 2);
    check("lock_score", bus.max_score, 'h4000);
    check("ovr_sticky", bus.overrun, 1);
    run_sample(-1, 0, 1, 'h7000);
    check("accwr_idx", bus.class_idx, 1);
    for (int f = 0; f < H; f++) fv[f] = int'($urandom_range(2047)) - 1024;
    for (int f = 0; f < 10; f++) send(fv[f], 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("mid_rst_ready", bus.feat_ready, 1);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_idx", bus.class_idx, 0);
    check("mid_rst_score", bus.max_score, 0);
    run_sample(-1, -1, 0, 0);
    for (int i = 0; i < H*K; i++) wm[i] = int'($urandom_range(1023)) - 512;
    for (int c = 0; c < K; c++) bm[c] = int'($urandom_range(65535)) - 32768;
    for (int f = 0; f < H; f++) fv[f] = int'($urandom_range(2047)) - 1024;
    load();
    run_sample(-1, -1, 0, 0);
    for (int i = 0; i < H*K; i++) wm[i] = 0;
    wm[0] = 1;
    for (int c = 0; c < K; c++) bm[c] = 0;
    for (int f = 0; f < H; f++) fv[f] = 0;
    fv[0] = 'h80;
    load();
    run_sample(-1, -1, 0, 0);
`ifdef DENSE_ROUND_EN
    check("round_score", bus.max_score, 1);
`else
    check("round_score", bus.max_score, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dense_argmax_head.md
Name: dense_argmax_head

Overview:
- Classifier head directly downstream of the GRU mean-pooling averager.
- Consumes the pooled hidden vector one element per averager `done_sig` pulse, H elements per sample.
- For each of K classes, computes a weighted sum plus a bias using a single time-shared multiplier.
- Saturates each class score to 16 bits, then outputs the argmax class index and its score with a one-cycle valid pulse.

Parameters:
- H, 32, pooled features per sample.
- K, 4, number of classes (≥2).
- DW, 16, feature/weight/bias/score width, signed.
- FRAC, 8, fractional bits of features, weights, biases and scores (Q7.8).
- ACCW, 40, accumulator width, signed.

Ports:
- clk  in  1  single clock (same clock as the averager's divider).
- rst  in  1  synchronous reset, active-high.
- feat_valid  in  1  pooled feature strobe (the averager's done_sig).
- feat_data  in  DW  pooled feature (the averager's ave_out), signed.
- feat_ready  out  1  block can accept a feature this cycle.
- w_we  in  1  weight write enable.
- w_addr  in  clog2(H*K)  weight address = feature*K + class.
- w_data  in  DW  weight, signed Q.FRAC.
- b_we  in  1  bias write enable.
- b_addr  in  clog2(K)  bias address = class.
- b_data  in  DW  bias, signed Q.FRAC.
- out_valid  out  1  one-cycle pulse; result is valid.
- class_idx  out  clog2(K)  argmax class.
- max_score  out  DW  score of the argmax class.
- overrun  out  1  sticky: a feature was presented while feat_ready=0.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over all activity, including mid-sample:
  - state=IDLE, feat_cnt=0, all K accumulators=0.
  - feat_ready=1, out_valid=0, class_idx=0, max_score=0, overrun=0.
  - Weight and bias memories are not cleared.
- States: IDLE, MAC, BIAS, ARGMAX, DONE.
- IDLE:
  - feat_ready=1.
  - When feat_valid=1, latch feat_data, go to MAC with cls=0.
- MAC:
  - feat_ready=0.
  - One class per cycle, K cycles: acc[cls] += feat * W[feat_cnt*K+cls].
  - The 2*DW product is sign-extended to ACCW.
  - After cls=K-1, increment feat_cnt:
    - feat_cnt==H → go to BIAS, clear feat_cnt.
    - otherwise → return to IDLE.
- BIAS:
  - K cycles, one class per cycle: score[c] = sat_DW((acc[c] + (B[c] <<< FRAC)) >>> FRAC).
  - The shift is arithmetic (truncation toward -inf).
  - sat clamps to [-32768, 32767].
  - Clear acc[c] after use.
- ARGMAX:
  - K cycles, sequential compare, strictly-greater updates.
  - Ties resolve to the lowest index.
- DONE:
  - out_valid=1 for exactly one cycle; class_idx and max_score update in the same cycle.
  - class_idx and max_score hold until the next DONE or reset.
  - Next state IDLE.
- Latency: the H-th feature is accepted at edge 0; out_valid is high in cycle 3K+1 (13 for K=4). Each feature occupies K+1 cycles of input bandwidth.
- Overrun: feat_valid=1 with feat_ready=0 sets overrun (sticky until rst); the feature is dropped and the state is unaffected.
- Writes:
  - w_we/b_we take effect only when state=IDLE and feat_cnt=0; otherwise they are ignored.
  - Simultaneous w_we and b_we are both honoured.
  - A write in the same cycle as an accepted feat_valid is still honoured, since the state is IDLE at that edge.
- Accumulator wrap: ACCW=40 guarantees no overflow for H≤256; wrap behaviour above that is undefined.

Optional Feature:
- Macro DENSE_ROUND_EN.
- Defined: BIAS adds 1<<(FRAC-1) before the arithmetic shift (round half up), then saturates.
- Undefined: plain truncating shift as described above.
- No other behavioural difference; latency is unchanged.

Test Plan:
- Reset idle: rst high 2 cycles → feat_ready=1, out_valid=0, class_idx=0, max_score=0, overrun=0.
- Basic sample, H=32, K=4:
  - Stimulus: all W=0x0100 (1.0) except W[f*4+2]=0x0200; biases 0; 32 features of 0x0080 (0.5).
  - Response: scores 16,16,32,16 (0x1000/0x2000); class_idx=2; max_score=0x2000; out_valid 13 cycles after the last accepted feature.
- Tie and bias:
  - Stimulus: all W=0; B={0x0100, 0x0300, 0x0300, -0x0100}.
  - Response: class_idx=1, max_score=0x0300.
- Saturation:
  - Stimulus: all W=0x7FFF; all features 0x7FFF.
  - Response: every score 0x7FFF, class_idx=0. Repeat with features 0x8000 → max_score 0x8000.
- Overrun and write lockout:
  - Stimulus: pulse feat_valid on the cycle after acceptance, and w_we at feat_cnt=5.
  - Response: overrun=1 and stays 1; the weight is unchanged (readback via a following all-ones sample); the sample result matches the non-overrun reference.
- Reset mid-sample:
  - Stimulus: assert rst after 10 features, then run a full 32-feature sample.
  - Response: result equals the fresh-sample result.
  - With DENSE_ROUND_EN, acc=0x0080 and bias 0 gives score 1 (without the macro, 0).
